// File: rtl/jtcps1_snd_romarb.sv
// Sound ROM arbiter: the Z80 program ROM and the OKI ADPCM ROM share one SDRAM
// read slot. Round-robin grant, a single outstanding SDRAM read, and a registered
// byte return with a per-client ok.
// Build option JTCPS1_ROMARB_CACHE_EN: each client keeps the whole 16-bit word, so
// the odd/even neighbour byte hits without another SDRAM access.
module jtcps1_snd_romarb #(
  parameter logic [21:0] ADPCM_OFFSET = 22'h08_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        z80_cs,
  input  logic [15:0] z80_addr,
  output logic [7:0]  z80_data,
  output logic        z80_ok,
  input  logic        adpcm_cs,
  input  logic [17:0] adpcm_addr,
  output logic [7:0]  adpcm_data,
  output logic        adpcm_ok,
  output logic [21:0] sdram_addr,
  output logic        sdram_cs,
  input  logic [15:0] sdram_data,
  input  logic        sdram_ok
);
`ifdef JTCPS1_ROMARB_CACHE_EN
  localparam int TL = 1;   // tag ignores addr[0]: word granularity
  localparam int DW = 16;
`else
  localparam int TL = 0;   // tag is the full byte address
  localparam int DW = 8;
`endif

  typedef enum logic { ST_IDLE, ST_WAIT } state_t;
  localparam logic CL_Z80 = 1'b0;
  localparam logic CL_ADPCM = 1'b1;

  state_t        state_q, state_d;
  logic          sdram_cs_q, sdram_cs_d;
  logic [21:0]   sdram_addr_q, sdram_addr_d;
  logic          last_q, last_d;     // client granted most recently
  logic          gnt_q, gnt_d;       // client owning the read in flight
  logic [17:TL]  lat_q, lat_d;       // address latched at grant
  logic [15:TL]  ztag_q, ztag_d;
  logic [17:TL]  atag_q, atag_d;
  logic [DW-1:0] zbuf_q, zbuf_d, abuf_q, abuf_d;
  logic          zvld_q, zvld_d, avld_q, avld_d;
  logic          zok_q, zok_d, aok_q, aok_d;
  logic [7:0]    zdat_q, zdat_d, adat_q, adat_d;

  logic [DW-1:0] ret;
  logic [7:0]    zbyte, abyte;
  logic          zhit, ahit, zmiss, amiss, pick;

`ifdef JTCPS1_ROMARB_CACHE_EN
  assign ret   = sdram_data;
  assign zbyte = z80_addr[0]   ? zbuf_q[15:8] : zbuf_q[7:0];
  assign abyte = adpcm_addr[0] ? abuf_q[15:8] : abuf_q[7:0];
`else
  assign ret   = lat_q[0] ? sdram_data[15:8] : sdram_data[7:0];
  assign zbyte = zbuf_q;
  assign abyte = abuf_q;
`endif

  assign zhit  = z80_cs   & zvld_q & (ztag_q == z80_addr[15:TL]);
  assign ahit  = adpcm_cs & avld_q & (atag_q == adpcm_addr[17:TL]);
  assign zmiss = z80_cs   & ~(zvld_q & (ztag_q == z80_addr[15:TL]));
  assign amiss = adpcm_cs & ~(avld_q & (atag_q == adpcm_addr[17:TL]));
  // on a tie the client that was not served last wins
  assign pick  = (zmiss & amiss) ? ~last_q : amiss;

  assign z80_data   = zdat_q;
  assign z80_ok     = zok_q;
  assign adpcm_data = adat_q;
  assign adpcm_ok   = aok_q;
  assign sdram_addr = sdram_addr_q;
  assign sdram_cs   = sdram_cs_q;

  // arbitration FSM, tag/data store and registered ok/data outputs
  always_comb begin
    state_d      = state_q;
    sdram_cs_d   = sdram_cs_q;
    sdram_addr_d = sdram_addr_q;
    last_d       = last_q;
    gnt_d        = gnt_q;
    lat_d        = lat_q;
    ztag_d       = ztag_q;
    atag_d       = atag_q;
    zbuf_d       = zbuf_q;
    abuf_d       = abuf_q;
    zvld_d       = zvld_q;
    avld_d       = avld_q;
    zok_d        = zhit;
    aok_d        = ahit;
    zdat_d       = zhit ? zbyte : zdat_q;
    adat_d       = ahit ? abyte : adat_q;
    case (state_q)
      ST_IDLE: begin
        if (zmiss | amiss) begin
          gnt_d      = pick;
          last_d     = pick;
          sdram_cs_d = 1'b1;
          state_d    = ST_WAIT;
          if (pick == CL_ADPCM) begin
            sdram_addr_d = ADPCM_OFFSET + {5'd0, adpcm_addr[17:1]};
            lat_d        = adpcm_addr[17:TL];
            avld_d       = 1'b0;
          end else begin
            sdram_addr_d = {7'd0, z80_addr[15:1]};
            lat_d        = {2'b00, z80_addr[15:TL]};
            zvld_d       = 1'b0;
          end
        end
      end
      ST_WAIT: begin
        // completes under the latched tag even if the client moved on
        if (sdram_ok) begin
          sdram_cs_d = 1'b0;
          state_d    = ST_IDLE;
          if (gnt_q == CL_ADPCM) begin
            atag_d = lat_q;
            abuf_d = ret;
            avld_d = 1'b1;
          end else begin
            ztag_d = lat_q[15:TL];
            zbuf_d = ret;
            zvld_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sdram_cs_q   <= 1'b0;
      sdram_addr_q <= '0;
      last_q       <= CL_ADPCM;
      gnt_q        <= CL_Z80;
      lat_q        <= '0;
      ztag_q       <= '0;
      atag_q       <= '0;
      zbuf_q       <= '0;
      abuf_q       <= '0;
      zvld_q       <= 1'b0;
      avld_q       <= 1'b0;
      zok_q        <= 1'b0;
      aok_q        <= 1'b0;
      zdat_q       <= '0;
      adat_q       <= '0;
    end else begin
      state_q      <= state_d;
      sdram_cs_q   <= sdram_cs_d;
      sdram_addr_q <= sdram_addr_d;
      last_q       <= last_d;
      gnt_q        <= gnt_d;
      lat_q        <= lat_d;
      ztag_q       <= ztag_d;
      atag_q       <= atag_d;
      zbuf_q       <= zbuf_d;
      abuf_q       <= abuf_d;
      zvld_q       <= zvld_d;
      avld_q       <= avld_d;
      zok_q        <= zok_d;
      aok_q        <= aok_d;
      zdat_q       <= zdat_d;
      adat_q       <= adat_d;
    end
  end
endmodule

// File: tb/tb_jtcps1_snd_romarb.sv
// Bench for jtcps1_snd_romarb: directed scenarios plus randomized traffic checked
// against an SDRAM content function, a request order rule and per-cycle ok/data rules.
module tb_jtcps1_snd_romarb;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        z80_cs = 1'b0, adpcm_cs = 1'b0, sdram_ok = 1'b0;
  logic [15:0] z80_addr = '0, sdram_data = '0;
  logic [17:0] adpcm_addr = '0;
  logic [7:0]  z80_data, adpcm_data;
  logic        z80_ok, adpcm_ok, sdram_cs;
  logic [21:0] sdram_addr;

  jtcps1_snd_romarb dut (
    .clk(clk), .rst_n(rst_n),
    .z80_cs(z80_cs), .z80_addr(z80_addr), .z80_data(z80_data), .z80_ok(z80_ok),
    .adpcm_cs(adpcm_cs), .adpcm_addr(adpcm_addr), .adpcm_data(adpcm_data),
    .adpcm_ok(adpcm_ok), .sdram_addr(sdram_addr), .sdram_cs(sdram_cs),
    .sdram_data(sdram_data), .sdram_ok(sdram_ok)
  );

  always #5 clk = ~clk;

  int checks = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // SDRAM image: any word address maps to a known value (word 0 = 16'hA55A)
  function automatic logic [15:0] memw(input logic [21:0] a);
    return 16'hA55A ^ a[15:0] ^ {10'd0, a[21:16]};
  endfunction
  function automatic logic [7:0] pick(input logic [15:0] w, input logic odd);
    return odd ? w[15:8] : w[7:0];
  endfunction
  function automatic logic [21:0] zw(input logic [15:0] a);
    return {7'd0, a[15:1]};
  endfunction
  function automatic logic [21:0] aw(input logic [17:0] a);
    return 22'h080000 + {5'd0, a[17:1]};
  endfunction

  typedef struct { logic [21:0] sa; logic [21:0] ze; logic [21:0] ae; } req_t;
  req_t reqs[$];

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // monitor: ok/data rules against the inputs sampled at the same edge, request log
  logic mr, mzc, mac, mpcs;
  logic [15:0] mza;
  logic [17:0] maa;
  initial forever begin
    @(posedge clk);
    mr = rst_n; mzc = z80_cs; mza = z80_addr; mac = adpcm_cs; maa = adpcm_addr;
    mpcs = sdram_cs;
    #2;
    if (mr) begin
      if (!mzc) chk("z80_ok_nocs", z80_ok, 0);
      else if (z80_ok) chk("z80_data", z80_data, pick(memw(zw(mza)), mza[0]));
      if (!mac) chk("adpcm_ok_nocs", adpcm_ok, 0);
      else if (adpcm_ok) chk("adpcm_data", adpcm_data, pick(memw(aw(maa)), maa[0]));
      if (sdram_cs && !mpcs) reqs.push_back('{sdram_addr, zw(mza), aw(maa)});
    end
  end

  // automatic SDRAM responder with random latency
  logic auto_rsp = 1'b0, pend = 1'b0, done = 1'b0;
  logic [21:0] cur;
  int dly;
  initial forever begin
    @(posedge clk); #1;
    if (auto_rsp) begin
      sdram_ok = 1'b0;
      if (done) begin done = 1'b0; chk("idle_gap", sdram_cs, 0); end
      if (pend) begin
        chk("cs_hold", sdram_cs, 1);
        chk("addr_hold", sdram_addr, cur);
        if (dly == 0) begin
          sdram_ok = 1'b1; sdram_data = memw(sdram_addr); pend = 1'b0; done = 1'b1;
        end else dly--;
      end else if (sdram_cs) begin
        pend = 1'b1; cur = sdram_addr; dly = $urandom_range(0, 3);
      end
    end
  end

  // random traffic: a client gets a fresh word address once it has its byte
  logic rnd_on = 1'b0;
  logic [15:0] v16;
  logic [17:0] v18;
  initial forever begin
    @(posedge clk); #1;
    if (rnd_on) begin
      if (z80_ok) begin
        do v16 = 16'($urandom); while (v16[15:1] == z80_addr[15:1]);
        z80_addr = v16;
      end
      if (adpcm_ok) begin
        do v18 = 18'($urandom); while (v18[17:1] == adpcm_addr[17:1]);
        adpcm_addr = v18;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, fails);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0; z80_cs = 1'b0; adpcm_cs = 1'b0; sdram_ok = 1'b0;
    tick(2);
    chk("rst_cs", sdram_cs, 0);
    chk("rst_addr", sdram_addr, 0);
    chk("rst_zok", z80_ok, 0);
    chk("rst_aok", adpcm_ok, 0);
    chk("rst_zdat", z80_data, 0);
    chk("rst_adat", adpcm_data, 0);
    rst_n = 1'b1;
  endtask

  task automatic get_req(input string tag, output req_t r);
    int n = 0;
    while (reqs.size() == 0 && n < 40) begin tick(); n++; end
    if (reqs.size() == 0) begin
      chk({tag, "_timeout"}, reqs.size(), 1);
      r = '{'x, 'x, 'x};
    end else r = reqs.pop_front();
  endtask

  task automatic wait_oks(input string tag, input logic wz, input logic wa);
    int n = 0;
    do begin tick(); n++; end
    while (((wz && !z80_ok) || (wa && !adpcm_ok)) && n < 60);
    if (wz) chk({tag, "_zok"}, z80_ok, 1);
    if (wa) chk({tag, "_aok"}, adpcm_ok, 1);
  endtask

  task automatic wait_cs(input string tag);
    int n = 0;
    while (!sdram_cs && n < 10) begin tick(); n++; end
    chk(tag, sdram_cs, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((pend || sdram_cs) && n < 50) begin tick(); n++; end
    chk("reach_idle", sdram_cs, 0);
  endtask

  task automatic pulse(input logic [15:0] d);
    sdram_ok = 1'b1; sdram_data = d; tick(); sdram_ok = 1'b0;
  endtask

  req_t r;
  logic exp_c;

  initial begin
    tick();
    do_reset();
    // 1: single Z80 read of word 0, manual SDRAM answer
    z80_cs = 1'b1; z80_addr = 16'h0000;
    wait_cs("t1_cs");
    chk("t1_addr", sdram_addr, 22'h000000);
    tick(2);
    chk("t1_hold", sdram_cs, 1);
    pulse(16'hA55A);
    chk("t1_cs_drop", sdram_cs, 0);
    chk("t1_ok_early", z80_ok, 0);
    tick();
    chk("t1_ok", z80_ok, 1);
    chk("t1_data", z80_data, 8'h5A);
    tick(3);
    chk("t1_no_reissue", sdram_cs, 0);
    z80_cs = 1'b0; tick();
    chk("t1_ok_drop", z80_ok, 0);
    chk("t1_data_hold", z80_data, 8'h5A);

    // 2: simultaneous requests, Z80 wins the first tie
    do_reset(); reqs.delete(); auto_rsp = 1'b1;
    z80_cs = 1'b1; z80_addr = 16'h8001; adpcm_cs = 1'b1; adpcm_addr = 18'h00004;
    get_req("t2a", r); chk("t2_first_z80", r.sa, 22'h004000);
    get_req("t2b", r); chk("t2_second_adpcm", r.sa, 22'h080002);
    wait_oks("t2", 1'b1, 1'b1);
    chk("t2_zdat", z80_data, pick(memw(22'h004000), 1'b1));
    chk("t2_adat", adpcm_data, pick(memw(22'h080002), 1'b0));
    z80_addr = 16'h8003;
    get_req("t2c", r); chk("t2_z80_alone", r.sa, 22'h004001);
    wait_oks("t2c", 1'b1, 1'b0);
    z80_addr = 16'h1234; adpcm_addr = 18'h00100;
    get_req("t2d", r); chk("t2_tie_adpcm", r.sa, 22'h080080);
    get_req("t2e", r); chk("t2_tie_z80", r.sa, 22'h00091A);
    wait_oks("t2e", 1'b1, 1'b1);

    // 3: ADPCM address moves during WAIT
    wait_idle(); auto_rsp = 1'b0; sdram_ok = 1'b0;
    z80_cs = 1'b0; adpcm_addr = 18'h00010;
    wait_cs("t3_cs");
    chk("t3_addr", sdram_addr, 22'h080008);
    adpcm_addr = 18'h00020;
    tick();
    pulse(memw(sdram_addr));
    chk("t3_ok_m", adpcm_ok, 0);
    tick();
    chk("t3_ok_m1", adpcm_ok, 0);
    chk("t3_recs", sdram_cs, 1);
    chk("t3_readdr", sdram_addr, 22'h080010);
    pulse(memw(22'h080010));
    tick();
    chk("t3_ok", adpcm_ok, 1);
    chk("t3_data", adpcm_data, pick(memw(22'h080010), 1'b0));

    // 4: reset in WAIT, late sdram_ok ignored, request re-issued
    adpcm_cs = 1'b0; z80_cs = 1'b1; z80_addr = 16'h0200;
    wait_cs("t4_cs");
    chk("t4_addr", sdram_addr, 22'h000100);
    rst_n = 1'b0; tick();
    chk("t4_rst_cs", sdram_cs, 0);
    chk("t4_rst_zok", z80_ok, 0);
    chk("t4_rst_aok", adpcm_ok, 0);
    chk("t4_rst_adat", adpcm_data, 0);
    rst_n = 1'b1;
    pulse(16'hDEAD);
    chk("t4_reissue", sdram_cs, 1);
    chk("t4_readdr", sdram_addr, 22'h000100);
    tick(2);
    chk("t4_no_ok", z80_ok, 0);
    pulse(memw(22'h000100));
    tick();
    chk("t4_ok", z80_ok, 1);
    chk("t4_data", z80_data, pick(memw(22'h000100), 1'b0));
    pulse(16'hDEAD);   // while IDLE: must be ignored
    tick();
    chk("t4_idle_cs", sdram_cs, 0);
    chk("t4_idle_data", z80_data, pick(memw(22'h000100), 1'b0));

    // 5: neighbour byte
    reqs.delete(); auto_rsp = 1'b1;
    z80_addr = 16'h0100;
    wait_oks("t5a", 1'b1, 1'b0);
    reqs.delete();
    z80_addr = 16'h0101;
`ifdef JTCPS1_ROMARB_CACHE_EN
    tick();
    chk("t5_hit_ok", z80_ok, 1);
    chk("t5_hit_data", z80_data, pick(memw(22'h000080), 1'b1));
    tick(3);
    chk("t5_no_sdram", reqs.size(), 0);
`else
    get_req("t5", r); chk("t5_miss_addr", r.sa, 22'h000080);
    wait_oks("t5b", 1'b1, 1'b0);
    chk("t5_data", z80_data, pick(memw(22'h000080), 1'b1));
`endif

    // 6: continuous misses from both clients, strict alternation
    wait_idle(); do_reset(); reqs.delete();
    z80_addr = 16'($urandom); adpcm_addr = 18'($urandom);
    z80_cs = 1'b1; adpcm_cs = 1'b1; rnd_on = 1'b1;
    exp_c = 1'b0;
    for (int i = 0; i < 200; i++) begin
      get_req("t6", r);
      chk("t6_order", r.sa, exp_c ? r.ae : r.ze);
      exp_c = ~exp_c;
    end
    rnd_on = 1'b0;

    // 7: random cs toggling over a small address set (hits and misses mixed)
    for (int i = 0; i < 400; i++) begin
      tick();
      if ($urandom_range(0, 3) == 0) z80_cs = ~z80_cs;
      if ($urandom_range(0, 3) == 0) adpcm_cs = ~adpcm_cs;
      if ($urandom_range(0, 2) == 0) z80_addr = 16'h0100 + 16'($urandom_range(0, 5));
      if ($urandom_range(0, 2) == 0) adpcm_addr = 18'h00200 + 18'($urandom_range(0, 5));
    end
    z80_cs = 1'b1; adpcm_cs = 1'b1;
    wait_oks("t7_final", 1'b1, 1'b1);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
